addsub_result_stage: RTL and testbench

ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

---
 rtl/addsub_result_stage_pkg.sv | 9 +
 rtl/addsub_result_stage_sat16.sv | 12 +
 rtl/addsub_result_stage.sv | 83 ++++++++
 tb/tb_addsub_result_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/addsub_result_stage_pkg.sv
// addsub_result_stage_pkg: shared types and constants for the add/sub result stage
package addsub_result_stage_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;
    localparam logic [7:0] OF_COUNT_MAX = 8'hFF;
endpackage

// File: rtl/addsub_result_stage_sat16.sv
// sat16: clamps an overflowed 16-bit result toward the true sign of the exact answer
module sat16
    import addsub_result_stage_pkg::*;
(
    input  logic [15:0] r,
    input  logic        f,
    input  logic        sat_en,
    output logic [15:0] sat_data
);
    // A wrapped result has the wrong sign, so a negative r means positive overflow
    always_comb sat_data = (sat_en && f) ? (r[15] ? SAT_MAX : SAT_MIN) : r;
endmodule

// File: rtl/addsub_result_stage.sv
// addsub_result_stage: selects, optionally saturates and buffers adder/subtractor results
module addsub_result_stage
    import addsub_result_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sum,
    input  logic [15:0] diff,
    input  logic        S_OF,
    input  logic        D_OF,
    input  logic        op,
    input  logic        sat_en,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_of,
    input  logic        clear_stats,
    output logic        sticky_of,
    output logic [7:0]  of_count
);
    state_t state;
    logic [15:0] d0, d1, r, sd;
    logic f0, f1, f, push, pop;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign r         = (op == OP_SUB) ? diff : sum;
    assign f         = (op == OP_SUB) ? D_OF : S_OF;
    assign out_data  = out_valid ? d0 : 16'h0000;
    assign out_of    = out_valid && f0;

    sat16 u_sat (.r(r), .f(f), .sat_en(sat_en), .sat_data(sd));

    // Two-entry in-order buffer: d0/f0 is the head presented downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            d0    <= '0;
            d1    <= '0;
            f0    <= 1'b0;
            f1    <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    d0    <= sd;
                    f0    <= f;
                    state <= ONE;
                end
                ONE: if (push && pop) begin
                    d0 <= sd;
                    f0 <= f;
                end else if (push) begin
                    d1    <= sd;
                    f1    <= f;
                    state <= TWO;
                end else if (pop) begin
                    state <= EMPTY;
                end
                TWO: if (pop) begin
                    d0    <= d1;
                    f0    <= f1;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Overflow statistics; clear wins over a same-cycle overflow push
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            sticky_of <= 1'b0;
            of_count  <= '0;
        end else if (push && f) begin
            sticky_of <= 1'b1;
            of_count  <= (of_count == OF_COUNT_MAX) ? of_count : of_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: directed self-checking bench for the add/sub result stage
module tb_addsub_result_stage;
    logic        clk = 1'b0;
    logic        rst, S_OF, D_OF, op, sat_en, in_valid, out_ready, clear_stats;
    logic [15:0] sum, diff;
    logic        in_ready, out_valid, out_of, sticky_of;
    logic [15:0] out_data;
    logic [7:0]  of_count;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    addsub_result_stage dut (
        .clk(clk), .rst(rst), .sum(sum), .diff(diff), .S_OF(S_OF), .D_OF(D_OF),
        .op(op), .sat_en(sat_en), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_of(out_of), .clear_stats(clear_stats), .sticky_of(sticky_of),
        .of_count(of_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic o, input logic [15:0] s, input logic so,
                         input logic [15:0] d, input logic dof, input logic se);
        op = o; sum = s; S_OF = so; diff = d; D_OF = dof; sat_en = se; in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
        op = 1'b0; sum = '0; diff = '0; S_OF = 1'b0; D_OF = 1'b0; sat_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_of", 16'(out_of), 16'h0);
        chk("rst_sticky", 16'(sticky_of), 16'h0);
        chk("rst_count", 16'(of_count), 16'h0);

        drive(1'b0, 16'h0003, 1'b0, 16'h5555, 1'b1, 1'b1);
        tick(); in_valid = 1'b0;
        chk("add_valid", 16'(out_valid), 16'h1);
        chk("add_data", out_data, 16'h0003);
        chk("add_of", 16'(out_of), 16'h0);
        chk("add_count", 16'(of_count), 16'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("pop_empty_valid", 16'(out_valid), 16'h0);
        chk("pop_empty_data", out_data, 16'h0000);

        drive(1'b0, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b1);
        tick(); in_valid = 1'b0;
        chk("satadd_data", out_data, 16'h7FFF);
        chk("satadd_of", 16'(out_of), 16'h1);
        chk("satadd_sticky", 16'(sticky_of), 16'h1);
        chk("satadd_count", 16'(of_count), 16'h1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        drive(1'b1, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        tick(); in_valid = 1'b0;
        chk("satsub_data", out_data, 16'h8000);
        chk("satsub_of", 16'(out_of), 16'h1);
        chk("satsub_count", 16'(of_count), 16'h2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        drive(1'b1, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        tick(); in_valid = 1'b0;
        chk("nosat_data", out_data, 16'h7FFF);
        chk("nosat_of", 16'(out_of), 16'h1);
        chk("nosat_count", 16'(of_count), 16'h3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        drive(1'b1, 16'h8000, 1'b1, 16'h1234, 1'b0, 1'b1);
        tick(); in_valid = 1'b0;
        chk("opsel_data", out_data, 16'h1234);
        chk("opsel_of", 16'(out_of), 16'h0);
        chk("opsel_count", 16'(of_count), 16'h3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        drive(1'b0, 16'h0011, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("bp_ready_one", 16'(in_ready), 16'h1);
        sum = 16'h0022;
        tick();
        chk("bp_ready_two", 16'(in_ready), 16'h0);
        chk("bp_head", out_data, 16'h0011);
        sum = 16'h0033; S_OF = 1'b1;
        tick(); in_valid = 1'b0;
        chk("bp_hold_data", out_data, 16'h0011);
        chk("bp_ignored_count", 16'(of_count), 16'h3);
        out_ready = 1'b1; tick();
        chk("bp_pop2_data", out_data, 16'h0022);
        chk("bp_pop2_ready", 16'(in_ready), 16'h1);
        chk("bp_pop2_valid", 16'(out_valid), 16'h1);
        tick();
        chk("bp_drained", 16'(out_valid), 16'h0);
        out_ready = 1'b0;

        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        chk("clr_count", 16'(of_count), 16'h0);
        chk("clr_sticky", 16'(sticky_of), 16'h0);
        out_ready = 1'b1;
        drive(1'b0, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) tick();
        chk("cnt_255", 16'(of_count), 16'h00FF);
        tick();
        chk("cnt_sat", 16'(of_count), 16'h00FF);
        chk("cnt_sticky", 16'(sticky_of), 16'h1);
        clear_stats = 1'b1;
        tick(); clear_stats = 1'b0; in_valid = 1'b0;
        chk("clrpri_count", 16'(of_count), 16'h0);
        chk("clrpri_sticky", 16'(sticky_of), 16'h0);
        chk("clrpri_of", 16'(out_of), 16'h1);
        chk("clrpri_valid", 16'(out_valid), 16'h1);
        tick(); out_ready = 1'b0;
        chk("clrpri_drained", 16'(out_valid), 16'h0);

        drive(1'b0, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b1);
        tick(); tick();
        chk("mid_two", 16'(in_ready), 16'h0);
        chk("mid_count", 16'(of_count), 16'h2);
        rst = 1'b1; out_ready = 1'b1; clear_stats = 1'b0;
        tick(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("midrst_valid", 16'(out_valid), 16'h0);
        chk("midrst_ready", 16'(in_ready), 16'h1);
        chk("midrst_data", out_data, 16'h0000);
        chk("midrst_of", 16'(out_of), 16'h0);
        chk("midrst_count", 16'(of_count), 16'h0);
        chk("midrst_sticky", 16'(sticky_of), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
